flash_playback_sequencer: RTL and testbench
===========================================

Name: flash_playback_sequencer

Overview:
- Sequences sample playback from a word-addressed flash reader: fetches 32-bit words and emits two 16-bit samples per word on sample-rate ticks.
- Steps the word address forward or backward with wrap-around in both directions.
- Sits between the keyboard/command decoder, the sample-rate tick divider, the flash read master and the audio output.

Parameters:
- ADDR_WIDTH, 23: width of the word address.
- MAX_ADDRESS, 'h80000: number of words; valid addresses are 0..MAX_ADDRESS-1.
- DATA_WIDTH, 32: flash word width.
- SAMPLE_WIDTH, 16: output sample width; DATA_WIDTH = 2*SAMPLE_WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; rst=0 at a clk edge resets the block.
- tick  in  1  one-cycle sample-rate strobe.
- cmd_play  in  1  pulse; set playing.
- cmd_pause  in  1  pulse; clear playing.
- cmd_forward  in  1  pulse; set direction forward.
- cmd_backward  in  1  pulse; set direction backward.
- cmd_restart  in  1  pulse; jump to the start of the current direction.
- rd_req  out  1  read request to the flash master.
- rd_addr  out  ADDR_WIDTH  word address for the read.
- rd_valid  in  1  one-cycle strobe; rd_data is valid and the request is complete.
- rd_data  in  DATA_WIDTH  word returned by the flash master.
- sample  out  SAMPLE_WIDTH  current output sample, held between strobes.
- sample_valid  out  1  one-cycle strobe when sample updates.
- playing  out  1  play/pause status.
- forward  out  1  1 = forward, 0 = backward.
- address  out  ADDR_WIDTH  current word address.

Behaviour:
- Reset values: state IDLE, address 0, forward 1, playing 0, rd_req 0, sample 0, sample_valid 0, restart_pending 0, latched word 0.
- Command precedence, same cycle:
  - cmd_pause beats cmd_play.
  - cmd_forward together with cmd_backward leaves direction unchanged.
  - Commands act in any state.
  - Direction change during a word applies to the next address step.
- FSM states:
  - IDLE: when tick and playing, go to READ; non-playing ticks are dropped.
  - READ: rd_req=1 and rd_addr=address, both held stable until rd_valid. On rd_valid, latch rd_data, drop rd_req the next cycle, go to FIRST.
  - FIRST: on the next tick with playing=1, emit the first half, strobe sample_valid, go to WAIT2. While paused, ticks are ignored and the state holds.
  - WAIT2: on the next tick with playing=1, emit the second half, strobe sample_valid, step the address, go to IDLE.
- Half order:
  - forward: emit [SAMPLE_WIDTH-1:0] first, then [DATA_WIDTH-1:SAMPLE_WIDTH].
  - backward: emit the upper half first, then the lower half.
- Address step, taken in WAIT2 on emit, using the direction at that cycle:
  - forward: address = MAX_ADDRESS-1 ? 0 : address+1.
  - backward: address = 0 ? MAX_ADDRESS-1 : address-1.
  - Address never leaves 0..MAX_ADDRESS-1.
- Restart:
  - cmd_restart sets restart_pending.
  - In IDLE, or at the WAIT2 emit instead of the normal step, load address = forward ? 0 : MAX_ADDRESS-1 and clear pending.
  - An in-flight READ is never aborted; the handshake always completes.
- Latency: read issued the cycle after an accepted tick; first sample on the first tick after rd_valid; at most one sample per tick.
- A tick arriving while in READ is dropped, with no backlog. The flash master must answer within one tick period.
- rst=0 mid-READ: rd_req falls on the next edge; the flash master is reset by the same rst.
- rd_valid outside READ is ignored.

Decomposition:
- Package flash_playback_pkg holds:
  - enum state_t {IDLE, READ, FIRST, WAIT2};
  - localparam SAMPLE_WIDTH;
  - function next_addr(addr, fwd, max) implementing the wrap rules.
- One natural sub-module, wrap_address_counter: up/down counter with load, wrap at 0 and MAX_ADDRESS-1, synchronous active-low rst. The FSM drives it.

Test Plan:
- Bench uses MAX_ADDRESS=4. Reset, cmd_play, 3 ticks, rd_valid with rd_data='hBBBB_AAAA -> rd_addr=0; samples 'hAAAA then 'hBBBB; address=1.
- Forward wrap: play from address 3 -> after the word, address=0; next rd_addr=0.
- Backward wrap: cmd_backward at address 0, data 'h1111_2222 -> samples 'h1111 then 'h2222; address=3.
- cmd_pause in FIRST, then 5 ticks -> no sample_valid. cmd_play, one tick -> first half emitted. Same-cycle play+pause -> playing=0.
- cmd_restart during READ with address=2, forward -> rd_req held until rd_valid; at the WAIT2 emit address=0, not 3. Backward restart -> address=3.
- rst=0 in READ with rd_req=1 -> next cycle rd_req=0, address=0, forward=1, playing=0, sample=0.

Source files
------------

// File: rtl/flash_playback_pkg.sv
// rtl/flash_playback_pkg.sv - shared types and address wrap helper for the playback sequencer
// Contents: state_t (sequencer states), SAMPLE_WIDTH, next_addr() wrap-around step.
package flash_playback_pkg;

   typedef enum logic [1:0] {IDLE, READ, FIRST, WAIT2} state_t;

   localparam int SAMPLE_WIDTH = 16;

   // One address step with wrap in either direction; callers cast to their own width.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fwd,
                                             input logic [31:0] max);
      if (fwd)
         return (addr == max - 32'd1) ? 32'd0 : addr + 32'd1;
      else
         return (addr == 32'd0) ? max - 32'd1 : addr - 32'd1;
   endfunction

endpackage

// File: rtl/flash_playback_sequencer_wrap_address_counter.sv
// rtl/flash_playback_sequencer_wrap_address_counter.sv - up/down word address counter with load and wrap
// Ports: clk, rst (sync active-low), load/load_value (priority load), step/up (one wrapped step), count.
module wrap_address_counter #(
   parameter int ADDR_WIDTH  = 23,
   parameter int MAX_ADDRESS = 'h80000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_value,
   input  logic                  step,
   input  logic                  up,
   output logic [ADDR_WIDTH-1:0] count
);
   import flash_playback_pkg::*;

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (step)
         count <= ADDR_WIDTH'(next_addr(32'(count), up, 32'(MAX_ADDRESS)));
   end

endmodule

// File: rtl/flash_playback_sequencer.sv
// rtl/flash_playback_sequencer.sv - fetches flash words and plays them out as two samples per word
// Ports: clk, rst (sync active-low), tick, cmd_* (play/pause/forward/backward/restart pulses),
//        rd_req/rd_addr/rd_valid/rd_data (flash read handshake), sample/sample_valid,
//        playing, forward, address (status).
module flash_playback_sequencer #(
   parameter int ADDR_WIDTH   = 23,
   parameter int MAX_ADDRESS  = 'h80000,
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic                    cmd_play,
   input  logic                    cmd_pause,
   input  logic                    cmd_forward,
   input  logic                    cmd_backward,
   input  logic                    cmd_restart,
   output logic                    rd_req,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic                    rd_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic [SAMPLE_WIDTH-1:0] sample,
   output logic                    sample_valid,
   output logic                    playing,
   output logic                    forward,
   output logic [ADDR_WIDTH-1:0]   address
);
   import flash_playback_pkg::*;

   state_t                  state;
   logic                    restart_pending;
   logic [DATA_WIDTH-1:0]   word;
   logic                    load;
   logic                    step;
   logic [ADDR_WIDTH-1:0]   load_value;

   // Address only moves in IDLE or WAIT2, so it is stable for the whole READ handshake.
   assign rd_addr    = address;
   assign load_value = forward ? '0 : ADDR_WIDTH'(MAX_ADDRESS - 1);

   // A pending restart replaces the normal step at the second-half emit.
   always_comb begin
      load = 1'b0;
      step = 1'b0;
      case (state)
         IDLE:    load = restart_pending;
         WAIT2:   if (tick && playing) begin
                     load = restart_pending;
                     step = !restart_pending;
                  end
         default: ;
      endcase
   end

   wrap_address_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_ADDRESS(MAX_ADDRESS)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_value(load_value),
      .step      (step),
      .up        (forward),
      .count     (address)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         rd_req          <= 1'b0;
         sample          <= '0;
         sample_valid    <= 1'b0;
         playing         <= 1'b0;
         forward         <= 1'b1;
         restart_pending <= 1'b0;
         word            <= '0;
      end else begin
         sample_valid <= 1'b0;

         if (cmd_pause)
            playing <= 1'b0;
         else if (cmd_play)
            playing <= 1'b1;

         // Both direction pulses together cancel out.
         if (cmd_forward && !cmd_backward)
            forward <= 1'b1;
         else if (cmd_backward && !cmd_forward)
            forward <= 1'b0;

         // A new restart request wins over the clear in the same cycle.
         restart_pending <= cmd_restart | (restart_pending & ~load);

         case (state)
            IDLE: if (tick && playing) begin
               rd_req <= 1'b1;
               state  <= READ;
            end
            READ: if (rd_valid) begin
               word   <= rd_data;
               rd_req <= 1'b0;
               state  <= FIRST;
            end
            FIRST: if (tick && playing) begin
               sample       <= forward ? word[SAMPLE_WIDTH-1:0] : word[DATA_WIDTH-1:SAMPLE_WIDTH];
               sample_valid <= 1'b1;
               state        <= WAIT2;
            end
            WAIT2: if (tick && playing) begin
               sample       <= forward ? word[DATA_WIDTH-1:SAMPLE_WIDTH] : word[SAMPLE_WIDTH-1:0];
               sample_valid <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// tb/tb_flash_playback_sequencer.sv - directed self-checking bench for flash_playback_sequencer
module tb_flash_playback_sequencer;

   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick = 1'b0;
   logic          cmd_play = 1'b0;
   logic          cmd_pause = 1'b0;
   logic          cmd_forward = 1'b0;
   logic          cmd_backward = 1'b0;
   logic          cmd_restart = 1'b0;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_valid = 1'b0;
   logic [31:0]   rd_data = '0;
   logic [15:0]   sample;
   logic          sample_valid;
   logic          playing;
   logic          forward;
   logic [AW-1:0] address;

   int checks = 0;
   int errors = 0;

   flash_playback_sequencer #(
      .ADDR_WIDTH  (AW),
      .MAX_ADDRESS (4),
      .DATA_WIDTH  (32),
      .SAMPLE_WIDTH(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .cmd_play    (cmd_play),
      .cmd_pause   (cmd_pause),
      .cmd_forward (cmd_forward),
      .cmd_backward(cmd_backward),
      .cmd_restart (cmd_restart),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .sample      (sample),
      .sample_valid(sample_valid),
      .playing     (playing),
      .forward     (forward),
      .address     (address)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs set before the call are sampled at this edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   // One full word from IDLE (playing): tick, read handshake, two emitting ticks.
   task automatic do_word(input string tag, input logic [31:0] data, input logic [AW-1:0] exp_rd_addr,
                          input logic [15:0] exp_first, input logic [15:0] exp_second,
                          input logic [AW-1:0] exp_addr_after);
      pulse_tick();
      check({tag, " rd_req"}, 32'(rd_req), 32'd1);
      check({tag, " rd_addr"}, 32'(rd_addr), 32'(exp_rd_addr));
      cyc();
      rd_valid = 1'b1;
      rd_data  = data;
      cyc();
      rd_valid = 1'b0;
      check({tag, " rd_req drop"}, 32'(rd_req), 32'd0);
      pulse_tick();
      check({tag, " first valid"}, 32'(sample_valid), 32'd1);
      check({tag, " first"}, 32'(sample), 32'(exp_first));
      cyc();
      check({tag, " valid one cycle"}, 32'(sample_valid), 32'd0);
      pulse_tick();
      check({tag, " second valid"}, 32'(sample_valid), 32'd1);
      check({tag, " second"}, 32'(sample), 32'(exp_second));
      check({tag, " addr after"}, 32'(address), 32'(exp_addr_after));
      cyc();
   endtask

   initial begin
      cyc();
      cyc();
      check("rst rd_req", 32'(rd_req), 32'd0);
      check("rst address", 32'(address), 32'd0);
      check("rst forward", 32'(forward), 32'd1);
      check("rst playing", 32'(playing), 32'd0);
      check("rst sample", 32'(sample), 32'd0);
      check("rst sample_valid", 32'(sample_valid), 32'd0);
      rst = 1'b1;
      cyc();

      // Non-playing tick is dropped.
      pulse_tick();
      check("idle tick dropped", 32'(rd_req), 32'd0);

      cmd_play = 1'b1;
      cyc();
      cmd_play = 1'b0;
      check("play", 32'(playing), 32'd1);

      do_word("w0", 32'hBBBB_AAAA, 0, 16'hAAAA, 16'hBBBB, 1);
      do_word("w1", 32'h1234_5678, 1, 16'h5678, 16'h1234, 2);
      do_word("w2", 32'h0F0F_F0F0, 2, 16'hF0F0, 16'h0F0F, 3);
      do_word("fwd wrap", 32'hDEAD_BEEF, 3, 16'hBEEF, 16'hDEAD, 0);

      cmd_backward = 1'b1;
      cyc();
      cmd_backward = 1'b0;
      check("backward", 32'(forward), 32'd0);
      do_word("bwd wrap", 32'h1111_2222, 0, 16'h1111, 16'h2222, 3);

      // Both direction pulses together: unchanged.
      cmd_forward  = 1'b1;
      cmd_backward = 1'b1;
      cyc();
      cmd_forward  = 1'b0;
      cmd_backward = 1'b0;
      check("fwd+bwd unchanged", 32'(forward), 32'd0);
      cmd_forward = 1'b1;
      cyc();
      cmd_forward = 1'b0;
      check("forward", 32'(forward), 32'd1);

      // Pause while in FIRST.
      pulse_tick();
      check("pause rd_addr", 32'(rd_addr), 32'd3);
      rd_valid = 1'b1;
      rd_data  = 32'h5555_6666;
      cyc();
      rd_valid  = 1'b0;
      cmd_pause = 1'b1;
      cyc();
      cmd_pause = 1'b0;
      check("paused", 32'(playing), 32'd0);
      for (int i = 0; i < 5; i++) begin
         pulse_tick();
         check("paused no sample", 32'(sample_valid), 32'd0);
      end
      cmd_play = 1'b1;
      cyc();
      cmd_play = 1'b0;
      pulse_tick();
      check("resume valid", 32'(sample_valid), 32'd1);
      check("resume first", 32'(sample), 32'h6666);
      pulse_tick();
      check("resume second", 32'(sample), 32'h5555);
      check("resume addr", 32'(address), 32'd0);

      cmd_play  = 1'b1;
      cmd_pause = 1'b1;
      cyc();
      cmd_play  = 1'b0;
      cmd_pause = 1'b0;
      check("play+pause", 32'(playing), 32'd0);
      cmd_play = 1'b1;
      cyc();
      cmd_play = 1'b0;

      // rd_valid outside READ is ignored.
      rd_valid = 1'b1;
      rd_data  = 32'hFFFF_FFFF;
      cyc();
      rd_valid = 1'b0;
      check("stray rd_valid", 32'(rd_req), 32'd0);

      do_word("w3", 32'h0000_0001, 0, 16'h0001, 16'h0000, 1);
      do_word("w4", 32'h0002_0003, 1, 16'h0003, 16'h0002, 2);

      // Restart during READ: handshake completes, restart replaces the step.
      pulse_tick();
      check("rs rd_addr", 32'(rd_addr), 32'd2);
      cmd_restart = 1'b1;
      cyc();
      cmd_restart = 1'b0;
      cyc();
      check("rs rd_req held", 32'(rd_req), 32'd1);
      check("rs rd_addr held", 32'(rd_addr), 32'd2);
      rd_valid = 1'b1;
      rd_data  = 32'hCAFE_BEEF;
      cyc();
      rd_valid = 1'b0;
      pulse_tick();
      check("rs first", 32'(sample), 32'hBEEF);
      pulse_tick();
      check("rs second", 32'(sample), 32'hCAFE);
      check("rs addr", 32'(address), 32'd0);
      cyc();

      // Backward restart from IDLE.
      cmd_backward = 1'b1;
      cyc();
      cmd_backward = 1'b0;
      cmd_restart = 1'b1;
      cyc();
      cmd_restart = 1'b0;
      cyc();
      check("bwd restart addr", 32'(address), 32'd3);

      // Reset in the middle of READ.
      pulse_tick();
      check("mid read rd_req", 32'(rd_req), 32'd1);
      rst = 1'b0;
      cyc();
      check("mid rst rd_req", 32'(rd_req), 32'd0);
      check("mid rst address", 32'(address), 32'd0);
      check("mid rst forward", 32'(forward), 32'd1);
      check("mid rst playing", 32'(playing), 32'd0);
      check("mid rst sample", 32'(sample), 32'd0);
      rst = 1'b1;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
